// File: rtl/unpacked_array_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unpacked_array_arb_pkg
//  Brief    : Shared types and width/address helpers for unpacked_array_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package unpacked_array_arb_pkg;

    // Controller state: zero-filling the array, or serving requesters
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    // $clog2 that never returns 0, so a degenerate dimension still gets a bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bank_w(input int num_banks);
        return clog2_min1(num_banks);
    endfunction

    function automatic int idx_w(input int depth);
        return clog2_min1(depth);
    endfunction

    function automatic int addr_w(input int num_banks, input int depth);
        return clog2_min1(num_banks * depth);
    endfunction

    // Bank-major flat address split: addr = bank*depth + idx
    function automatic int flat_bank(input int addr, input int depth);
        return addr / depth;
    endfunction

    function automatic int flat_idx(input int addr, input int depth);
        return addr % depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Round-robin arbiter, combinational one-hot grant, registered
//             pointer holding the last granted requester
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import unpacked_array_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] r_ptr;
    int              w_cand;

    // Search cyclically from the requester after the last winner
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        w_cand    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = (int'(r_ptr) + off) % NUM_REQ;
            if (!grant_any && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                grant_id      = ID_W'(w_cand);
                grant_any     = 1'b1;
            end
        end
    end

    // Pointer moves only on an actual grant; reset makes requester 0 win first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            r_ptr <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unpacked_array_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unpacked_array_arbiter
//  Brief    : Shares one 2-D unpacked array between NUM_REQ requesters with
//             round-robin arbitration and a built-in zero-fill sequencer
//  Revision : 1.0 - initial release
// ============================================================================
module unpacked_array_arbiter
    import unpacked_array_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int NUM_BANKS = 4,
    parameter  int DEPTH     = 8,
    parameter  int WIDTH     = 8,
    localparam int BANK_W    = bank_w(NUM_BANKS),
    localparam int IDX_W     = idx_w(DEPTH),
    localparam int ID_W      = clog2_min1(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][BANK_W-1:0] req_bank,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_idx,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_wdata,
    input  logic                           clear_req,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [WIDTH-1:0]               rsp_rdata,
    output logic                           rsp_err,
    output logic                           busy
);

    localparam int c_TOTAL  = NUM_BANKS * DEPTH;
    localparam int c_ADDR_W = addr_w(NUM_BANKS, DEPTH);

    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_clr_addr;
    logic [WIDTH-1:0]      r_mem [NUM_BANKS][DEPTH];

    logic [NUM_REQ-1:0]    w_req;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gid;
    logic                  w_fire;
    logic                  w_sel_we;
    logic [BANK_W-1:0]     w_sel_bank;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [WIDTH-1:0]      w_sel_wdata;
    logic                  w_in_range;
    logic [BANK_W-1:0]     w_clr_bank;
    logic [IDX_W-1:0]      w_clr_idx;
    logic                  w_clr_last;

    // Requests are only visible to the arbiter while serving
    assign w_req     = req_valid & {NUM_REQ{r_state == SERVE}};
    assign req_ready = w_grant;
    assign busy      = (r_state == CLEAR);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req),
        .grant     (w_grant),
        .grant_id  (w_gid),
        .grant_any (w_fire)
    );

    // Payload of the winning requester
    assign w_sel_we    = req_we[w_gid];
    assign w_sel_bank  = req_bank[w_gid];
    assign w_sel_idx   = req_idx[w_gid];
    assign w_sel_wdata = req_wdata[w_gid];
    assign w_in_range  = (int'(w_sel_bank) < NUM_BANKS) && (int'(w_sel_idx) < DEPTH);

    // Clear address decomposed bank-major
    assign w_clr_bank = BANK_W'(flat_bank(int'(r_clr_addr), DEPTH));
    assign w_clr_idx  = IDX_W'(flat_idx(int'(r_clr_addr), DEPTH));
    assign w_clr_last = (r_clr_addr == c_ADDR_W'(c_TOTAL - 1));

    // Clear sequencer / serve state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (w_clr_last) begin
                        r_state    <= SERVE;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_ADDR_W'(1);
                    end
                end
                SERVE: begin
                    if (clear_req) begin
                        r_state    <= CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                default: begin
                    r_state    <= CLEAR;
                    r_clr_addr <= '0;
                end
            endcase
        end
    end

    // Array port: zero-fill while clearing, granted in-range writes while serving
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[w_clr_bank][w_clr_idx] <= '0;
        end else if (w_fire && w_sel_we && w_in_range) begin
            r_mem[w_sel_bank][w_sel_idx] <= w_sel_wdata;
        end
    end

    // Registered read response; id/data/err hold between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_fire && !w_sel_we;
            if (w_fire && !w_sel_we) begin
                rsp_id    <= w_gid;
                rsp_rdata <= w_in_range ? r_mem[w_sel_bank][w_sel_idx] : '0;
                rsp_err   <= !w_in_range;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unpacked_array_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unpacked_array_arbiter
//  Brief    : Directed, table-driven bench for unpacked_array_arbiter
//             (default geometry plus a DEPTH=6 instance)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unpacked_array_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid, req_ready, req_we;
    logic [3:0][1:0]  req_bank;
    logic [3:0][2:0]  req_idx;
    logic [3:0][7:0]  req_wdata;
    logic             clear_req;
    logic             rsp_valid, rsp_err, busy;
    logic [1:0]       rsp_id;
    logic [7:0]       rsp_rdata;

    logic [3:0]       d6_valid, d6_ready, d6_we;
    logic [3:0][1:0]  d6_bank;
    logic [3:0][2:0]  d6_idx;
    logic [3:0][7:0]  d6_wdata;
    logic             d6_clear_req;
    logic             d6_rsp_valid, d6_rsp_err, d6_busy;
    logic [1:0]       d6_rsp_id;
    logic [7:0]       d6_rsp_rdata;

    int checks;
    int errors;

    typedef struct {
        int         id;
        bit         we;
        logic [1:0] bank;
        logic [2:0] idx;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    unpacked_array_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_bank  (req_bank),
        .req_idx   (req_idx),
        .req_wdata (req_wdata),
        .clear_req (clear_req),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    unpacked_array_arbiter #(.DEPTH(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (d6_valid),
        .req_ready (d6_ready),
        .req_we    (d6_we),
        .req_bank  (d6_bank),
        .req_idx   (d6_idx),
        .req_wdata (d6_wdata),
        .clear_req (d6_clear_req),
        .rsp_valid (d6_rsp_valid),
        .rsp_id    (d6_rsp_id),
        .rsp_rdata (d6_rsp_rdata),
        .rsp_err   (d6_rsp_err),
        .busy      (d6_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One transfer on requester id of the selected instance; returns at posedge+1
    task automatic access(input bit d6, input int id, input bit we, input logic [1:0] b,
                          input logic [2:0] ix, input logic [7:0] wd);
        bit ok;
        @(posedge clk);
        #1;
        if (d6) begin
            d6_valid[id] = 1'b1; d6_we[id] = we; d6_bank[id] = b;
            d6_idx[id] = ix; d6_wdata[id] = wd;
        end else begin
            req_valid[id] = 1'b1; req_we[id] = we; req_bank[id] = b;
            req_idx[id] = ix; req_wdata[id] = wd;
        end
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (d6 ? d6_ready[id] : req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("access_ready", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        if (d6) d6_valid[id] = 1'b0;
        else    req_valid[id] = 1'b0;
    endtask

    task automatic check_rsp(input bit d6, input int id, input logic [7:0] data, input bit err);
        @(negedge clk);
        if (d6) begin
            chk("d6_rsp_valid", {31'd0, d6_rsp_valid}, 32'd1);
            chk("d6_rsp_id",    {30'd0, d6_rsp_id}, id);
            chk("d6_rsp_rdata", {24'd0, d6_rsp_rdata}, {24'd0, data});
            chk("d6_rsp_err",   {31'd0, d6_rsp_err}, {31'd0, err});
        end else begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_id",    {30'd0, rsp_id}, id);
            chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, data});
            chk("rsp_err",   {31'd0, rsp_err}, {31'd0, err});
        end
    endtask

    task automatic check_no_rsp(input bit d6);
        @(negedge clk);
        chk(d6 ? "d6_no_rsp" : "no_rsp", {31'd0, d6 ? d6_rsp_valid : rsp_valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{0, 1'b1, 2'd0, 3'd0, 8'h11, 8'h00};
        tbl[1] = '{1, 1'b1, 2'd3, 3'd7, 8'hFF, 8'h00};
        tbl[2] = '{2, 1'b1, 2'd1, 3'd4, 8'h5A, 8'h00};
        tbl[3] = '{3, 1'b0, 2'd0, 3'd0, 8'h00, 8'h11};
        tbl[4] = '{0, 1'b0, 2'd3, 3'd7, 8'h00, 8'hFF};
        tbl[5] = '{1, 1'b0, 2'd1, 3'd4, 8'h00, 8'h5A};
        tbl[6] = '{2, 1'b0, 2'd2, 3'd2, 8'h00, 8'h00};
        tbl[7] = '{3, 1'b1, 2'd0, 3'd0, 8'h22, 8'h00};
        tbl[8] = '{0, 1'b0, 2'd0, 3'd0, 8'h00, 8'h22};
        tbl[9] = '{1, 1'b0, 2'd1, 3'd3, 8'h00, 8'h00};

        rst = 1'b1;
        clear_req = 1'b0;
        d6_clear_req = 1'b0;
        req_valid = 4'hF; req_we = 4'h0; req_wdata = '0;
        req_bank = {4{2'd3}}; req_idx = {4{3'd7}};
        d6_valid = '0; d6_we = '0; d6_bank = '0; d6_idx = '0; d6_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",      {31'd0, busy}, 32'd1);
        chk("reset_ready",     {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id",    {30'd0, rsp_id}, 32'd0);
        chk("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        // Clear lasts 32 cycles with no grants despite all valids high
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("init_clear_busy",  {31'd0, busy}, 32'd1);
            chk("init_clear_ready", {28'd0, req_ready}, 32'd0);
        end

        // Round-robin rotation, each read of [3][7] returns zero
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rr_busy",  {31'd0, busy}, 32'd0);
            chk("rr_grant", {28'd0, req_ready}, 32'd1 << (j % 4));
            if (j == 0) begin
                chk("rr_first_no_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rr_rsp_id",    {30'd0, rsp_id}, (j - 1) % 4);
                chk("rr_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
                chk("rr_rsp_err",   {31'd0, rsp_err}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        check_rsp(0, 3, 8'h00, 1'b0);
        check_no_rsp(0);

        // Table-driven writes and read-backs
        for (int i = 0; i < 10; i++) begin
            access(0, tbl[i].id, tbl[i].we, tbl[i].bank, tbl[i].idx, tbl[i].wdata);
            if (tbl[i].we) check_no_rsp(0);
            else           check_rsp(0, tbl[i].id, tbl[i].exp_rdata, 1'b0);
        end

        // Write by req1 at N, read by req3 at N+1
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_bank[1] = 2'd2; req_idx[1] = 3'd5;
        req_wdata[1] = 8'hA5;
        @(negedge clk);
        chk("wr_grant_req1", {28'd0, req_ready}, 32'h2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1; req_we[3] = 1'b0; req_bank[3] = 2'd2; req_idx[3] = 3'd5;
        @(negedge clk);
        chk("rd_grant_req3", {28'd0, req_ready}, 32'h8);
        chk("no_rsp_after_wr", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        check_rsp(0, 3, 8'hA5, 1'b0);

        // clear_req coinciding with a granted read
        @(posedge clk);
        #1;
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_bank[2] = 2'd2; req_idx[2] = 3'd5;
        clear_req = 1'b1;
        @(negedge clk);
        chk("clr_grant_req2", {28'd0, req_ready}, 32'h4);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        clear_req = 1'b0;
        check_rsp(0, 2, 8'hA5, 1'b0);
        chk("clr_busy_first", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            chk("reclear_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("reclear_done", {31'd0, busy}, 32'd0);
        access(0, 1, 1'b0, 2'd2, 3'd5, 8'h00);
        check_rsp(0, 1, 8'h00, 1'b0);

        // Asynchronous reset between acceptance and response
        access(0, 0, 1'b0, 2'd0, 3'd0, 8'h00);
        #1;
        chk("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rst_busy",      {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("rst_clear_busy",   {31'd0, busy}, 32'd1);
            chk("rst_clear_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        chk("rst_clear_done", {31'd0, busy}, 32'd0);
        chk("d6_clear_done",  {31'd0, d6_busy}, 32'd0);

        // DEPTH=6: out-of-range index and no aliasing
        access(1, 0, 1'b0, 2'd0, 3'd7, 8'h00);
        check_rsp(1, 0, 8'h00, 1'b1);
        access(1, 0, 1'b1, 2'd0, 3'd7, 8'h3C);
        check_no_rsp(1);
        access(1, 0, 1'b0, 2'd0, 3'd5, 8'h00);
        check_rsp(1, 0, 8'h00, 1'b0);
        access(1, 2, 1'b1, 2'd1, 3'd5, 8'h77);
        check_no_rsp(1);
        access(1, 2, 1'b0, 2'd1, 3'd5, 8'h00);
        check_rsp(1, 2, 8'h77, 1'b0);
        access(1, 1, 1'b0, 2'd0, 3'd6, 8'h00);
        check_rsp(1, 1, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
